// File: rtl/accum_drain_if.sv
// rtl/accum_drain_if.sv - result beat stream between accum_drain and the host result writer
interface accum_drain_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_WIDTH-1:0] m_index;
    logic [31:0]           m_key;
    logic [31:0]           m_count;

    modport master (output m_valid, output m_index, output m_key, output m_count, input m_ready);
    modport slave  (input m_valid, input m_index, input m_key, input m_count, output m_ready);
endinterface

// File: rtl/accum_drain.sv
// rtl/accum_drain.sv - sweeps the accumulator array and streams {index, key, count} beats
// Optional: ACCUM_DRAIN_SKIP_ZERO_EN drops entries whose count is zero at capture.
module accum_drain #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [31:0]           rd_addr,
    input  logic [63:0]           rd_q,
    accum_drain_if.master         m,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   n_emitted
);
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   ptr;
    logic                  inflight;
    logic [ADDR_WIDTH-1:0] inflight_idx;
    logic [ADDR_WIDTH-1:0] buf_idx  [2];
    logic [63:0]           buf_data [2];
    logic [1:0]            occ;
    logic [1:0]            occ_after;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign m.m_valid = (occ != 2'd0);
    assign m.m_index = buf_idx[0];
    assign m.m_key   = buf_data[0][63:32];
    assign m.m_count = buf_data[0][31:0];
    assign busy      = (state == SCAN) || (state == FLUSH);
    assign done      = (state == DONE);

    // Past the final issue the pointer holds 2**ADDR_WIDTH; keep the address on the last entry.
    assign rd_addr = 32'(ptr[ADDR_WIDTH] ? {ADDR_WIDTH{1'b1}} : ptr[ADDR_WIDTH-1:0]);

    assign pop       = m.m_valid & m.m_ready;
    assign occ_after = occ - {1'b0, pop};

`ifdef ACCUM_DRAIN_SKIP_ZERO_EN
    assign push = inflight && (rd_q[31:0] != 32'd0);
`else
    assign push = inflight;
`endif

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                // A slot is reserved for every read in flight, so the FIFO never overflows.
                issue = ((occ_after + {1'b0, inflight}) < 2'd2);
                if (issue && (ptr == LAST_ADDR)) state_nxt = FLUSH;
            end
            FLUSH: if (!inflight && (occ_after == 2'd0)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
            occ          <= 2'd0;
            n_emitted    <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_idx[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            state        <= state_nxt;
            inflight     <= issue;
            if (issue) inflight_idx <= ptr[ADDR_WIDTH-1:0];
            if (state == IDLE && start) begin
                ptr       <= '0;
                n_emitted <= '0;
            end else begin
                if (issue) ptr       <= ptr + 1'b1;
                if (pop)   n_emitted <= n_emitted + 1'b1;
            end
            if (pop) begin
                buf_idx[0]  <= buf_idx[1];
                buf_data[0] <= buf_data[1];
            end
            // Written after the shift so a push into the vacated head slot takes priority.
            if (push) begin
                buf_idx[occ_after[0]]  <= inflight_idx;
                buf_data[occ_after[0]] <= rd_q;
            end
            occ <= occ_after + {1'b0, push};
        end
    end
endmodule

// File: tb/tb_accum_drain.sv
// tb/tb_accum_drain.sv - randomized self-checking bench for accum_drain against a queue model
module tb_accum_drain;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

`ifdef ACCUM_DRAIN_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   rd_addr;
    logic [63:0]   rd_q;
    logic          busy;
    logic          done;
    logic [AW:0]   n_emitted;
    logic [63:0]   mem [DEPTH];

    int n_vec = 0;
    int n_err = 0;

    accum_drain_if #(.ADDR_WIDTH(AW)) sif ();

    accum_drain #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_q      (rd_q),
        .m         (sif),
        .busy      (busy),
        .done      (done),
        .n_emitted (n_emitted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= mem[rd_addr[AW-1:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_image(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0: mem[i] = {32'hA0 + 32'(i), 32'(i)};
                1: mem[i] = 64'd0;
                default: mem[i] = {$urandom, ($urandom_range(2) == 0) ? 32'd0 : $urandom};
            endcase
        end
    endtask

    // Reference: every address in order, minus zero-count entries when skipping is built in.
    task automatic run_sweep(input int pct, input bit spam);
        logic [AW+63:0] exp_q[$];
        logic [AW+63:0] beat, prev_beat;
        bit             prev_hold;
        bit             got_done;
        int             n_pop, busy_cyc, last_pop_cyc, done_cyc;
        for (int i = 0; i < DEPTH; i++)
            if (!(SKIP && mem[i][31:0] == 32'd0)) exp_q.push_back({AW'(i), mem[i]});
        prev_hold = 0; got_done = 0; n_pop = 0; busy_cyc = 0; last_pop_cyc = -1; done_cyc = -1;
        prev_beat = '0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            sif.m_ready = ($urandom_range(99) < pct);
            beat = {sif.m_index, sif.m_key, sif.m_count};
            if (prev_hold) begin
                check("hold_valid", 64'(sif.m_valid), 64'd1);
                check("hold_beat", 64'(beat != prev_beat), 64'd0);
            end
            if (busy) busy_cyc++;
            if (sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0) check("extra_beat", 64'd1, 64'd0);
                else begin
                    check("beat_index", 64'(sif.m_index), 64'(exp_q[0][AW+63:64]));
                    check("beat_key",   64'(sif.m_key),   64'(exp_q[0][63:32]));
                    check("beat_count", 64'(sif.m_count), 64'(exp_q[0][31:0]));
                    void'(exp_q.pop_front());
                end
                n_pop++;
                last_pop_cyc = cyc;
            end
            prev_hold = sif.m_valid && !sif.m_ready;
            prev_beat = beat;
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                start = spam;
                break;
            end
            start = spam && busy && ($urandom_range(1) == 1);
            @(negedge clk);
        end
        check("done_seen", 64'(got_done), 64'd1);
        check("beats_left", 64'(exp_q.size()), 64'd0);
        check("n_emitted", 64'(n_emitted), 64'(n_pop));
        if (pct == 100) check("busy_cycles", 64'(busy_cyc), 64'(DEPTH + 2));
        if (got_done && !(SKIP && mem[DEPTH-1][31:0] == 32'd0))
            check("done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) start = 1'b0;
            check("post_done", 64'({done, busy, sif.m_valid}), 64'd0);
        end
    endtask

    task automatic reset_mid_sweep();
        int n_pop, n_done;
        bit hit;
        n_pop = 0; n_done = 0; hit = 0;
        sif.m_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (sif.m_valid && sif.m_ready) n_pop++;
            if (n_pop == 7) begin
                hit = 1;
                reset = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reset_reached_7", 64'(hit), 64'd1);
        @(negedge clk) reset = 1'b0;
        check("rst_valid", 64'(sif.m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_n_emitted", 64'(n_emitted), 64'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy || sif.m_valid) n_done++;
        end
        check("rst_quiet", 64'(n_done), 64'd0);
    endtask

    initial begin
        sif.m_ready = 1'b0;
        load_image(0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_rd_addr", 64'(rd_addr), 64'd0);
        check("reset_valid", 64'(sif.m_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_n_emitted", 64'(n_emitted), 64'd0);

        run_sweep(100, 1'b0);
        run_sweep(30, 1'b0);
        run_sweep(100, 1'b1);
        reset_mid_sweep();
        run_sweep(100, 1'b0);
        load_image(1);
        run_sweep(100, 1'b0);
        for (int t = 0; t < 4; t++) begin
            load_image(2);
            run_sweep(60, t[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
